// File: rtl/dac_wave_sequencer.sv
// rtl/dac_wave_sequencer.sv - 16-step DAC waveform sequencer with prescaler and boundary-aligned mode switch
module dac_wave_sequencer #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] k,
    output logic [3:0] out,
    output logic [1:0] mode,
    output logic       sample_stb,
    output logic       period_done,
    output logic       sw_pending
);

    localparam int W = $clog2(DIV) + 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state;
    logic [3:0]   phase;
    logic [W-1:0] div_cnt;
    logic         step;
    logic [3:0]   phase_next;

    assign step       = (div_cnt == LAST);
    assign phase_next = phase + 4'd1;

    // Waveform table: falling half of the triangle is 15-2q, i.e. the bitwise inverse of 2q.
    function automatic logic [3:0] wave(input logic [1:0] m, input logic [3:0] p);
        logic [3:0] v;
        v = 4'd0;
        case (m)
            2'b00: v = p;
            2'b01: v = p[3] ? ~{p[2:0], 1'b0} : {p[2:0], 1'b0};
            2'b10: v = {4{p[3]}};
            default: begin
                case (p)
                    4'd0:  v = 4'd8;
                    4'd1:  v = 4'd11;
                    4'd2:  v = 4'd13;
                    4'd3:  v = 4'd15;
                    4'd4:  v = 4'd15;
                    4'd5:  v = 4'd15;
                    4'd6:  v = 4'd13;
                    4'd7:  v = 4'd11;
                    4'd8:  v = 4'd8;
                    4'd9:  v = 4'd5;
                    4'd10: v = 4'd3;
                    4'd11: v = 4'd1;
                    4'd12: v = 4'd0;
                    4'd13: v = 4'd1;
                    4'd14: v = 4'd3;
                    default: v = 4'd5;
                endcase
            end
        endcase
        return v;
    endfunction

    // Main sequencer: run/idle control, prescaler, phase stepping and wrap-time mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out         <= 4'd0;
            mode        <= 2'b00;
            phase       <= 4'd0;
            div_cnt     <= '0;
            sample_stb  <= 1'b0;
            period_done <= 1'b0;
        end else begin
            sample_stb  <= 1'b0;
            period_done <= 1'b0;
            case (state)
                IDLE: begin
                    phase   <= 4'd0;
                    div_cnt <= '0;
                    if (en) begin
                        state <= RUN;
                        mode  <= k;
                        out   <= wave(k, 4'd0);
                    end else begin
                        out <= 4'd0;
                    end
                end
                default: begin
                    if (!en) begin
                        // Disable wins over a coincident step: park the DAC, no pulses.
                        state   <= IDLE;
                        out     <= 4'd0;
                        phase   <= 4'd0;
                        div_cnt <= '0;
                    end else if (step) begin
                        div_cnt    <= '0;
                        sample_stb <= 1'b1;
                        phase      <= phase_next;
                        if (phase == 4'd15) begin
                            // Period boundary: the only point where a new shape is adopted.
                            mode        <= k;
                            out         <= wave(k, 4'd0);
                            period_done <= 1'b1;
                        end else begin
                            out <= wave(mode, phase_next);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Flag a requested shape that is still waiting for the next period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_pending <= 1'b0;
        end else begin
            sw_pending <= (state == RUN) && (k != mode);
        end
    end

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// tb/tb_dac_wave_sequencer.sv - self-checking bench for dac_wave_sequencer (DIV=2 and DIV=1 instances)
module tb_dac_wave_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [1:0] k;

    logic [3:0] out0, out1;
    logic [1:0] mode0, mode1;
    logic       stb0, stb1, pd0, pd1, sw0, sw1;

    dac_wave_sequencer #(.DIV(2)) u_div2 (
        .clk(clk), .rst(rst), .en(en), .k(k),
        .out(out0), .mode(mode0), .sample_stb(stb0),
        .period_done(pd0), .sw_pending(sw0)
    );

    dac_wave_sequencer #(.DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .k(k),
        .out(out1), .mode(mode1), .sample_stb(stb1),
        .period_done(pd1), .sw_pending(sw1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time since entering RUN determines phase and step instants.
    int divs[2]  = '{2, 1};
    int sine[16] = '{8, 11, 13, 15, 15, 15, 13, 11, 8, 5, 3, 1, 0, 1, 3, 5};
    bit m_run[2];
    int m_cyc[2];
    int m_mode[2];
    int e_out[2];
    int e_stb[2];
    int e_pd[2];
    int e_sw[2];

    function automatic int wave(int m, int p);
        case (m)
            0: return p;
            1: return (p < 8) ? 2 * p : 31 - 2 * p;
            2: return (p < 8) ? 0 : 15;
            default: return sine[p];
        endcase
    endfunction

    function automatic int phase_of(int i);
        return (m_cyc[i] / divs[i]) % 16;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            e_sw[i] = (m_run[i] && (int'(k) != m_mode[i])) ? 1 : 0;
            e_stb[i] = 0;
            e_pd[i]  = 0;
            if (rst) begin
                m_run[i]  = 1'b0;
                m_cyc[i]  = 0;
                m_mode[i] = 0;
                e_out[i]  = 0;
                e_sw[i]   = 0;
            end else if (!m_run[i]) begin
                if (en) begin
                    m_run[i]  = 1'b1;
                    m_cyc[i]  = 0;
                    m_mode[i] = int'(k);
                    e_out[i]  = wave(m_mode[i], 0);
                end else begin
                    e_out[i] = 0;
                end
            end else if (!en) begin
                m_run[i] = 1'b0;
                e_out[i] = 0;
            end else begin
                m_cyc[i]++;
                if (m_cyc[i] % divs[i] == 0) begin
                    if (phase_of(i) == 0) m_mode[i] = int'(k);
                    e_out[i] = wave(m_mode[i], phase_of(i));
                    e_stb[i] = 1;
                    e_pd[i]  = (phase_of(i) == 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input int exp);
        checks++;
        assert (obs === 4'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_div2",  out0,        e_out[0]);
        chk("mode_div2", {2'b0, mode0}, m_mode[0]);
        chk("stb_div2",  {3'b0, stb0}, e_stb[0]);
        chk("pd_div2",   {3'b0, pd0},  e_pd[0]);
        chk("sw_div2",   {3'b0, sw0},  e_sw[0]);
        chk("out_div1",  out1,        e_out[1]);
        chk("mode_div1", {2'b0, mode1}, m_mode[1]);
        chk("stb_div1",  {3'b0, stb1}, e_stb[1]);
        chk("pd_div1",   {3'b0, pd1},  e_pd[1]);
        chk("sw_div1",   {3'b0, sw1},  e_sw[1]);
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    // Advance until the DIV=2 instance has just stepped onto phase p (bounded).
    task automatic run_until_phase(input int p);
        bit hit;
        hit = 1'b0;
        for (int j = 0; j < 80 && !hit; j++) begin
            tick();
            if (m_run[0] && e_stb[0] == 1 && phase_of(0) == p) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_phase observed=timeout expected=phase %0d", p);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_cyc[i] = 0; m_mode[i] = 0;
            e_out[i] = 0; e_stb[i] = 0; e_pd[i] = 0; e_sw[i] = 0;
        end
        rst = 1'b1; en = 1'b0; k = 2'b00;

        // Reset, then stay idle
        ticks(2);
        rst = 1'b0;
        ticks(40);

        // Saw, full periods
        en = 1'b1; k = 2'b00;
        ticks(40);

        // Request triangle mid-period, then cancel before the wrap
        run_until_phase(2);
        k = 2'b01;
        ticks(4);
        k = 2'b00;
        ticks(40);

        // Switch to square at phase 5, takes effect at the wrap
        run_until_phase(5);
        k = 2'b10;
        ticks(40);

        // Sine (DIV=1 instance steps every cycle)
        k = 2'b11;
        ticks(40);

        // Triangle, then reset mid-period at phase 9 and restart
        k = 2'b01;
        ticks(40);
        run_until_phase(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(20);

        // Disable mid-run, re-enable
        en = 1'b0;
        ticks(5);
        en = 1'b1;
        ticks(10);

        // Randomized traffic
        for (int j = 0; j < 600; j++) begin
            rst = ($urandom % 60 == 0);
            en  = ($urandom % 25 != 0);
            if ($urandom % 8 == 0) k = 2'($urandom % 4);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
